// File: rtl/dispatch_rr.sv
// Dispatch stage: steers renamed instructions into per-FU FIFOs and drains one
// entry per cycle to its reservation station using round-robin arbitration.
module dispatch_rr #(
    parameter int NUM_FU    = 3,
    parameter int BUF_DEPTH = 2,
    parameter int NUM_CDB   = 3,
    parameter int PREG_W    = 7,
    parameter int ROB_W     = 5,
    parameter int PAYLOAD_W = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_FU-1:0]           in_fu_sel,
    input  logic [PREG_W-1:0]           in_pd_new,
    input  logic [PREG_W-1:0]           in_pd_old,
    input  logic [PREG_W-1:0]           in_ps1,
    input  logic [PREG_W-1:0]           in_ps2,
    input  logic [31:0]                 in_pc,
    input  logic [ROB_W-1:0]            in_rob_tag,
    input  logic [PAYLOAD_W-1:0]        in_payload,
    output logic                        busy_valid,
    output logic [PREG_W-1:0]           busy_preg,
    output logic [NUM_FU-1:0]           rs_valid,
    input  logic [NUM_FU-1:0]           rs_ready,
    output logic [PREG_W-1:0]           rs_pd_new,
    output logic [PREG_W-1:0]           rs_ps1,
    output logic [PREG_W-1:0]           rs_ps2,
    output logic                        rs_ps1_ready,
    output logic                        rs_ps2_ready,
    output logic [ROB_W-1:0]            rs_rob_tag,
    output logic [31:0]                 rs_pc,
    output logic [PAYLOAD_W-1:0]        rs_payload,
    output logic [PREG_W-1:0]           query_ps1,
    output logic [PREG_W-1:0]           query_ps2,
    input  logic                        pr1_is_ready,
    input  logic                        pr2_is_ready,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0]   cdb_preg,
    input  logic                        rob_full,
    output logic                        rob_we,
    output logic [PREG_W-1:0]           rob_pd_new,
    output logic [PREG_W-1:0]           rob_pd_old,
    output logic [31:0]                 rob_pc,
    input  logic                        mispredict,
    output logic                        sel_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [PREG_W-1:0]    pdNew;
        logic [PREG_W-1:0]    pdOld;
        logic [PREG_W-1:0]    ps1;
        logic [PREG_W-1:0]    ps2;
        logic [31:0]          pc;
        logic [ROB_W-1:0]     robTag;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           r_mem   [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0] r_wrPtr [NUM_FU];
    logic [PTR_W-1:0] r_rdPtr [NUM_FU];
    logic [CNT_W-1:0] r_count [NUM_FU];
    logic [RR_W-1:0]  r_rrPtr;

    logic              w_oneHot;
    logic              w_accept;
    logic [NUM_FU-1:0] w_notFull;
    logic [NUM_FU-1:0] w_eligible;
    logic [NUM_FU-1:0] w_push;
    logic [NUM_FU-1:0] w_pop;
    logic              w_grantValid;
    logic [RR_W-1:0]   w_grantIdx;
    int                w_scanIdx;
    entry_t            w_head;
    entry_t            w_newEntry;
    logic              w_hit1;
    logic              w_hit2;

    always_comb begin
        w_oneHot = (in_fu_sel != '0) && ((in_fu_sel & (in_fu_sel - NUM_FU'(1))) == '0);
        for (int i = 0; i < NUM_FU; i++) begin
            w_notFull[i]  = r_count[i] < CNT_W'(BUF_DEPTH);
            w_eligible[i] = (r_count[i] != '0) && rs_ready[i] && !rob_full && !mispredict;
        end
    end

    // Space check uses only registered counts, so a same-cycle drain never frees a slot.
    assign in_ready   = !mispredict && (!w_oneHot || |(in_fu_sel & w_notFull));
    assign w_accept   = in_valid && in_ready;
    assign w_push     = (w_accept && w_oneHot) ? in_fu_sel : '0;
    assign busy_valid = w_accept && w_oneHot && (in_pd_new != '0);
    assign busy_preg  = busy_valid ? in_pd_new : '0;
    assign sel_err    = w_accept && !w_oneHot;

    assign w_newEntry = '{pdNew: in_pd_new, pdOld: in_pd_old, ps1: in_ps1, ps2: in_ps2,
                          pc: in_pc, robTag: in_rob_tag, payload: in_payload};

    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_scanIdx    = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            w_scanIdx = int'(r_rrPtr) + j;
            if (w_scanIdx >= NUM_FU) w_scanIdx = w_scanIdx - NUM_FU;
            if (!w_grantValid && w_eligible[RR_W'(w_scanIdx)]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = RR_W'(w_scanIdx);
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            w_pop[i] = w_grantValid && (w_grantIdx == RR_W'(i));
        end
    end

    assign w_head = r_mem[w_grantIdx][r_rdPtr[w_grantIdx]];

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && (cdb_preg[k*PREG_W +: PREG_W] == w_head.ps1)) w_hit1 = 1'b1;
            if (cdb_valid[k] && (cdb_preg[k*PREG_W +: PREG_W] == w_head.ps2)) w_hit2 = 1'b1;
        end
    end

    assign rs_valid     = w_grantValid ? (NUM_FU'(1) << w_grantIdx) : '0;
    assign rob_we       = w_grantValid;
    assign rs_pd_new    = w_grantValid ? w_head.pdNew   : '0;
    assign rs_ps1       = w_grantValid ? w_head.ps1     : '0;
    assign rs_ps2       = w_grantValid ? w_head.ps2     : '0;
    assign rs_rob_tag   = w_grantValid ? w_head.robTag  : '0;
    assign rs_pc        = w_grantValid ? w_head.pc      : '0;
    assign rs_payload   = w_grantValid ? w_head.payload : '0;
    assign query_ps1    = rs_ps1;
    assign query_ps2    = rs_ps2;
    assign rob_pd_new   = rs_pd_new;
    assign rob_pd_old   = w_grantValid ? w_head.pdOld : '0;
    assign rob_pc       = rs_pc;
    assign rs_ps1_ready = w_grantValid && ((w_head.ps1 == '0) || pr1_is_ready || w_hit1);
    assign rs_ps2_ready = w_grantValid && ((w_head.ps2 == '0) || pr2_is_ready || w_hit2);

    // Flush clears occupancy but keeps the arbitration pointer where it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_count[i] <= '0;
            end
            r_rrPtr <= '0;
        end else if (mispredict) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_mem[i][r_wrPtr[i]] <= w_newEntry;
                    r_wrPtr[i]           <= r_wrPtr[i] + PTR_W'(1);
                end
                if (w_pop[i]) r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
                if (w_push[i] && !w_pop[i]) r_count[i] <= r_count[i] + CNT_W'(1);
                else if (!w_push[i] && w_pop[i]) r_count[i] <= r_count[i] - CNT_W'(1);
            end
            if (w_grantValid) begin
                r_rrPtr <= (w_grantIdx == RR_W'(NUM_FU - 1)) ? '0 : w_grantIdx + RR_W'(1);
            end
        end
    end

endmodule
